instr_fetch_unit: RTL and testbench
===================================

INSTR_FETCH_UNIT -- requirements
Module: instr_fetch_unit

Interface
REQ-001 SHALL have port clk  input  1  sole clock; all state updates on the rising edge.
REQ-002 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-003 SHALL have port PCSrc  input  1  branch taken for the current instruction, from the controller.
REQ-004 SHALL have port Jump  input  1  jump for the current instruction, from the controller.
REQ-005 SHALL have port immediate  input  32  sign-extended branch offset, in words.
REQ-006 SHALL have port Jump_immediate  input  26  jump target field.
REQ-007 SHALL have port exec_done  input  1  core has executed the presented instruction.
REQ-008 SHALL have port imem_req  output  1  instruction memory read request.
REQ-009 SHALL have port imem_addr  output  12  word address, equal to pc[13:2].
REQ-010 SHALL have port imem_rdata  input  32  instruction word returned by memory.
REQ-011 SHALL have port imem_ack  input  1  imem_rdata is valid this cycle.
REQ-012 SHALL have port instruction  output  32  registered instruction presented to the core.
REQ-013 SHALL have port instr_valid  output  1  instruction holds a fetched word.
REQ-014 SHALL have port pc  output  32  address of the presented or in-flight instruction.
REQ-015 SHALL have port fetch_err  output  1  sticky memory-timeout flag.
REQ-016 SHALL have parameter RESET_VECTOR, default 32'h0000_0000, initial pc.
REQ-017 SHALL have parameter TIMEOUT, default 255, maximum wait cycles for imem_ack.

Function
REQ-018 SHALL use the FSM states IDLE, REQ and VALID.
REQ-019 IDLE SHALL last exactly one cycle after reset release and then go to REQ.
REQ-020 In REQ: imem_req=1 and imem_addr=pc[13:2]; on imem_ack, instruction<=imem_rdata and the state goes to VALID; imem_ack in the same cycle as the first req cycle SHALL be accepted, giving instr_valid=1 on the next cycle.
REQ-021 In VALID: instr_valid=1, imem_req=0, and instruction and pc held stable until exec_done=1.
REQ-022 On exec_done=1 in VALID: pc<=next_pc, the state goes to REQ, and instr_valid=0 from the next cycle.
REQ-023 next_pc SHALL have priority Jump > PCSrc > sequential.
- Jump: {pc_plus4[31:28], Jump_immediate, 2'b00}
- PCSrc: pc_plus4 + (immediate<<2)
- sequential: pc_plus4 = pc+4
REQ-024 All pc arithmetic SHALL be modulo 2^32; 32'hFFFF_FFFC+4 wraps to 0.
REQ-025 PCSrc, Jump, immediate and Jump_immediate SHALL be sampled only in the cycle where exec_done=1 in VALID.
REQ-026 exec_done outside VALID, and imem_ack outside REQ, SHALL be ignored.
REQ-027 A wait counter SHALL clear on entry to REQ and increment each REQ cycle without ack.
REQ-028 When the wait counter reaches TIMEOUT: fetch_err<=1 (sticky until reset), the state returns to REQ, and the same pc is re-requested with the counter cleared.

Reset
REQ-029 On rst=1, asynchronously and regardless of state:
- state=IDLE, pc=RESET_VECTOR, instruction=32'h0000_0000 (nop)
- instr_valid=0, imem_req=0, fetch_err=0, wait counter=0
REQ-030 A reset during REQ or VALID SHALL discard the outstanding fetch; an imem_ack arriving after reset release while in IDLE is ignored.

Structure
REQ-031 A shared package SHALL hold the state encoding, RESET_VECTOR default, the NOP constant and the PC increment of 4.
REQ-032 next-PC computation SHALL be a combinational sub-module pc_next_logic; the FSM, pc register and counter stay in instr_fetch_unit.

Verification
REQ-033 Reset, then ack one cycle after req with rdata=32'h2008_0005 -> imem_addr=0, instr_valid=1, instruction=32'h2008_0005, pc=0.
REQ-034 Two exec_done pulses with no branch -> next requests at pc=4 then pc=8 (imem_addr 1, 2).
REQ-035 pc=32'h40, PCSrc=1, immediate=32'hFFFF_FFFE, exec_done -> next pc=32'h3C; then Jump=1, Jump_immediate=26'h10 with PCSrc=1 -> pc=32'h40 (jump wins).
REQ-036 Hold imem_ack=0 for TIMEOUT cycles -> fetch_err=1, req reissued at the same address; a later ack is accepted and fetch_err stays 1.
REQ-037 Assert rst in VALID with pc=32'h80 -> same-cycle instr_valid=0, imem_req=0, pc=0; after release, IDLE for one cycle, then req at address 0.
REQ-038 pc=32'hFFFF_FFFC, sequential exec_done -> pc wraps to 32'h0.

Source files
------------

// File: rtl/instr_fetch_unit_pkg.sv
// rtl/instr_fetch_unit_pkg.sv - shared types and constants for the instruction fetch unit
package instr_fetch_unit_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_REQ   = 2'd1,
        ST_VALID = 2'd2
    } state_t;

    localparam logic [31:0] RESET_VECTOR_DEFAULT = 32'h0000_0000;
    localparam logic [31:0] NOP                  = 32'h0000_0000;
    localparam logic [31:0] PC_INC               = 32'd4;

endpackage

// File: rtl/instr_fetch_unit_pc_next_logic.sv
// rtl/instr_fetch_unit_pc_next_logic.sv - combinational next-pc select (jump > branch > sequential)
module pc_next_logic
    import instr_fetch_unit_pkg::*;
(
    input  logic [31:0] pc_i,
    input  logic        pcsrc_i,
    input  logic        jump_i,
    input  logic [31:0] immediate_i,
    input  logic [25:0] jump_imm_i,
    output logic [31:0] next_pc_o
);

    logic [31:0] pc_plus4;

    assign pc_plus4 = pc_i + PC_INC;

    always_comb begin
        next_pc_o = pc_plus4;
        if (jump_i) begin
            next_pc_o = {pc_plus4[31:28], jump_imm_i, 2'b00};
        end else if (pcsrc_i) begin
            // word offset scaled to bytes; arithmetic wraps modulo 2^32
            next_pc_o = pc_plus4 + (immediate_i << 2);
        end
    end

endmodule

// File: rtl/instr_fetch_unit.sv
// rtl/instr_fetch_unit.sv - fetch FSM, pc register and memory-timeout watchdog
module instr_fetch_unit
    import instr_fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_VECTOR = RESET_VECTOR_DEFAULT,
    parameter int unsigned TIMEOUT      = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        PCSrc,
    input  logic        Jump,
    input  logic [31:0] immediate,
    input  logic [25:0] Jump_immediate,
    input  logic        exec_done,
    output logic        imem_req,
    output logic [11:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        imem_ack,
    output logic [31:0] instruction,
    output logic        instr_valid,
    output logic [31:0] pc,
    output logic        fetch_err
);

    localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] WAIT_LAST = CW'(TIMEOUT - 1);

    state_t        state_q, state_d;
    logic [31:0]   pc_q, pc_d;
    logic [31:0]   instr_q, instr_d;
    logic [CW-1:0] wait_q, wait_d;
    logic          err_q, err_d;
    logic [31:0]   next_pc;

    pc_next_logic u_pc_next (
        .pc_i        (pc_q),
        .pcsrc_i     (PCSrc),
        .jump_i      (Jump),
        .immediate_i (immediate),
        .jump_imm_i  (Jump_immediate),
        .next_pc_o   (next_pc)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            pc_q    <= RESET_VECTOR;
            instr_q <= NOP;
            wait_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
            wait_q  <= wait_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  state_d = ST_REQ;
            ST_REQ:   if (imem_ack) state_d = ST_VALID;
            ST_VALID: if (exec_done) state_d = ST_REQ;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        pc_d    = pc_q;
        instr_d = instr_q;
        wait_d  = wait_q;
        err_d   = err_q;
        case (state_q)
            ST_REQ: begin
                if (imem_ack) begin
                    instr_d = imem_rdata;
                    wait_d  = '0;
                end else if (wait_q == WAIT_LAST) begin
                    // timed out: flag it and keep requesting the same pc
                    err_d  = 1'b1;
                    wait_d = '0;
                end else begin
                    wait_d = wait_q + CW'(1);
                end
            end
            ST_VALID: begin
                wait_d = '0;
                if (exec_done) pc_d = next_pc;
            end
            default: wait_d = '0;
        endcase
    end

    always_comb begin
        imem_req    = (state_q == ST_REQ);
        instr_valid = (state_q == ST_VALID);
    end

    assign imem_addr   = pc_q[13:2];
    assign instruction = instr_q;
    assign pc          = pc_q;
    assign fetch_err   = err_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb/tb_instr_fetch_unit.sv - self-checking bench for instr_fetch_unit
module tb_instr_fetch_unit;

    localparam int TIMEOUT = 255;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        PCSrc = 1'b0;
    logic        Jump = 1'b0;
    logic [31:0] immediate = '0;
    logic [25:0] Jump_immediate = '0;
    logic        exec_done = 1'b0;
    logic        imem_req;
    logic [11:0] imem_addr;
    logic [31:0] imem_rdata = '0;
    logic        imem_ack = 1'b0;
    logic [31:0] instruction;
    logic        instr_valid;
    logic [31:0] pc;
    logic        fetch_err;

    int vectors = 0;
    int miscompares = 0;

    logic [31:0] m_pc;
    logic [31:0] m_instr;
    logic        m_err;

    instr_fetch_unit #(.RESET_VECTOR(32'h0000_0000), .TIMEOUT(TIMEOUT)) dut (
        .clk            (clk),
        .rst            (rst),
        .PCSrc          (PCSrc),
        .Jump           (Jump),
        .immediate      (immediate),
        .Jump_immediate (Jump_immediate),
        .exec_done      (exec_done),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_rdata     (imem_rdata),
        .imem_ack       (imem_ack),
        .instruction    (instruction),
        .instr_valid    (instr_valid),
        .pc             (pc),
        .fetch_err      (fetch_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    function automatic logic [31:0] ref_next(input logic [31:0] cur, input logic br, input logic jp,
                                             input logic [31:0] imm, input logic [25:0] jimm);
        logic [31:0] seq;
        seq = cur + 32'd4;
        if (jp) return (seq & 32'hF000_0000) | ({6'd0, jimm} * 4);
        if (br) return seq + imm * 4;
        return seq;
    endfunction

    task automatic fetch(input int lat, input logic [31:0] word);
        chk("req_asserted", 32'(imem_req), 32'd1);
        chk("req_addr", 32'(imem_addr), 32'(m_pc[13:2]));
        chk("req_not_valid", 32'(instr_valid), 32'd0);
        imem_ack = 1'b0;
        for (int i = 0; i < lat; i++) begin
            imem_rdata = $urandom;
            exec_done  = 1'($urandom);
            tick();
        end
        imem_ack   = 1'b1;
        imem_rdata = word;
        exec_done  = 1'($urandom);
        tick();
        imem_ack   = 1'b0;
        exec_done  = 1'b0;
        imem_rdata = $urandom;
        m_instr    = word;
        chk("valid_after_ack", 32'(instr_valid), 32'd1);
        chk("req_dropped", 32'(imem_req), 32'd0);
        chk("instruction", instruction, m_instr);
        chk("pc_held", pc, m_pc);
        chk("fetch_err", 32'(fetch_err), 32'(m_err));
    endtask

    task automatic hold(input int n);
        for (int i = 0; i < n; i++) begin
            exec_done      = 1'b0;
            PCSrc          = 1'($urandom);
            Jump           = 1'($urandom);
            immediate      = $urandom;
            Jump_immediate = 26'($urandom);
            imem_ack       = 1'($urandom);
            imem_rdata     = $urandom;
            tick();
            chk("hold_valid", 32'(instr_valid), 32'd1);
            chk("hold_instr", instruction, m_instr);
            chk("hold_pc", pc, m_pc);
        end
        imem_ack = 1'b0;
    endtask

    task automatic exec(input logic br, input logic jp, input logic [31:0] imm, input logic [25:0] jimm);
        PCSrc          = br;
        Jump           = jp;
        immediate      = imm;
        Jump_immediate = jimm;
        exec_done      = 1'b1;
        imem_ack       = 1'b0;
        m_pc = ref_next(m_pc, br, jp, imm, jimm);
        tick();
        exec_done      = 1'b0;
        PCSrc          = 1'($urandom);
        Jump           = 1'($urandom);
        immediate      = $urandom;
        Jump_immediate = 26'($urandom);
        chk("exec_pc", pc, m_pc);
        chk("exec_valid_low", 32'(instr_valid), 32'd0);
        chk("exec_req", 32'(imem_req), 32'd1);
        chk("exec_addr", 32'(imem_addr), 32'(m_pc[13:2]));
    endtask

    initial begin
        m_pc    = 32'h0;
        m_instr = 32'h0;
        m_err   = 1'b0;

        // power-on reset
        rst = 1'b1;
        tick();
        tick();
        chk("rst_valid", 32'(instr_valid), 32'd0);
        chk("rst_req", 32'(imem_req), 32'd0);
        chk("rst_pc", pc, 32'h0);
        chk("rst_instr", instruction, 32'h0);
        chk("rst_err", 32'(fetch_err), 32'd0);

        // release with a stray ack that IDLE must ignore
        rst        = 1'b0;
        imem_ack   = 1'b1;
        imem_rdata = 32'hDEAD_BEEF;
        #1;
        chk("idle_req", 32'(imem_req), 32'd0);
        tick();
        imem_ack = 1'b0;
        chk("first_req", 32'(imem_req), 32'd1);
        chk("first_not_valid", 32'(instr_valid), 32'd0);
        chk("first_addr", 32'(imem_addr), 32'd0);

        // first fetch, ack one cycle after req
        fetch(1, 32'h2008_0005);
        chk("first_instr", instruction, 32'h2008_0005);
        hold(3);

        // sequential fetches
        exec(1'b0, 1'b0, 32'h0, 26'h0);
        chk("seq_addr1", 32'(imem_addr), 32'd1);
        fetch(0, $urandom);
        exec(1'b0, 1'b0, 32'h0, 26'h0);
        chk("seq_addr2", 32'(imem_addr), 32'd2);
        fetch(2, $urandom);

        // branch backwards, then jump beating a simultaneous branch
        exec(1'b0, 1'b1, 32'h0, 26'h10);
        chk("jump_40", pc, 32'h40);
        fetch(1, $urandom);
        exec(1'b1, 1'b0, 32'hFFFF_FFFE, 26'h0);
        chk("branch_3c", pc, 32'h3C);
        fetch(0, $urandom);
        exec(1'b1, 1'b1, 32'hFFFF_FFFE, 26'h10);
        chk("jump_wins", pc, 32'h40);
        fetch(3, $urandom);

        // pc wrap-around
        exec(1'b1, 1'b0, (32'hFFFF_FFFC - m_pc - 32'd4) >> 2, 26'h0);
        chk("pc_top", pc, 32'hFFFF_FFFC);
        fetch(1, $urandom);
        exec(1'b0, 1'b0, 32'h0, 26'h0);
        chk("pc_wrap", pc, 32'h0);

        // memory timeout
        for (int i = 1; i <= TIMEOUT; i++) begin
            imem_ack = 1'b0;
            tick();
            if (i == TIMEOUT - 1) chk("err_before_timeout", 32'(fetch_err), 32'd0);
        end
        m_err = 1'b1;
        chk("err_at_timeout", 32'(fetch_err), 32'd1);
        chk("timeout_req", 32'(imem_req), 32'd1);
        chk("timeout_addr", 32'(imem_addr), 32'd0);
        tick();
        fetch(2, 32'h1234_5678);
        chk("err_sticky", 32'(fetch_err), 32'd1);

        // reset while VALID at pc 0x80
        exec(1'b0, 1'b1, 32'h0, 26'h20);
        chk("pc_80", pc, 32'h80);
        fetch(1, $urandom);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_valid", 32'(instr_valid), 32'd0);
        chk("arst_req", 32'(imem_req), 32'd0);
        chk("arst_pc", pc, 32'h0);
        chk("arst_instr", instruction, 32'h0);
        chk("arst_err", 32'(fetch_err), 32'd0);
        tick();
        rst     = 1'b0;
        m_pc    = 32'h0;
        m_err   = 1'b0;
        m_instr = 32'h0;
        #1;
        chk("rel_idle", 32'(imem_req), 32'd0);
        tick();
        chk("rel_req", 32'(imem_req), 32'd1);
        chk("rel_addr", 32'(imem_addr), 32'd0);
        fetch(0, $urandom);

        // randomized traffic
        repeat (25) begin
            hold(int'($urandom_range(0, 3)));
            exec(($urandom_range(0, 2) == 0), ($urandom_range(0, 3) == 0), $urandom, 26'($urandom));
            fetch(int'($urandom_range(0, 4)), $urandom);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
